// File: rtl/z80_io_pkg.sv
// Shared definitions for the NextZ80 I/O-mapped UART: register offsets,
// status bit positions and the serial state machine encodings.
package z80_io_pkg;

  localparam logic [7:0] REG_DATA   = 8'd0;
  localparam logic [7:0] REG_STATUS = 8'd1;

  localparam int ST_RX_READY  = 0;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/z80_io_uart_if.sv
// CPU-side I/O bus bundle for the UART: the CPU drives the master side,
// the UART answers on the slave side.
interface z80_io_uart_if;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       wr;
  logic       iorq;
  logic [7:0] rdata;
  logic       sel;

  modport master (output addr, wdata, wr, iorq, input rdata, sel);
  modport slave  (input addr, wdata, wr, iorq, output rdata, sel);
endinterface

// File: rtl/z80_io_uart_rx.sv
// 8N1 serial receiver: 2-flop synchronizer, mid-bit sampling FSM, one-cycle
// pulses for a good byte or a framing error.
module uart_rx
  import z80_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  logic      sync1_q, sync2_q, prev_q;
  rx_state_e state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          baud_d  = '0;
        end
      end
      RX_START: begin
        // Half a bit in: a line that went back high was only a glitch.
        if (baud_q == HALF_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          state_d = RX_IDLE;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_byte  = shift_q;
  assign rx_valid = valid_q;
  assign rx_ferr  = ferr_q;

endmodule

// File: rtl/z80_io_uart.sv
// I/O-mapped 8N1 UART for the NextZ80: data/status ports, one-byte TX hold,
// TX shifter and receive flags.
module z80_io_uart
  import z80_io_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR    = 8'h00,
  parameter int         CLKS_PER_BIT = 104
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_data,
  input  logic       i_wr,
  input  logic       i_iorq,
  output logic [7:0] o_data,
  output logic       o_sel,
  input  logic       i_rx,
  output logic       o_tx
);

  localparam logic [7:0]  DATA_ADDR   = BASE_ADDR + REG_DATA;
  localparam logic [7:0]  STATUS_ADDR = BASE_ADDR + REG_STATUS;
  localparam logic [15:0] BIT_LAST    = 16'(CLKS_PER_BIT - 1);

  logic       iorq_q;
  logic       sel_data, sel_status, strobe;
  logic       data_wr_stb, data_rd_stb, status_rd_stb;
  logic [7:0] status_byte;

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr;

  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_baud_q, tx_baud_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_q, tx_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        tx_take;

  logic [7:0] rx_buf_q, rx_buf_d;
  logic       rx_ready_q, rx_ready_d;
  logic       overrun_q, overrun_d;
  logic       frame_err_q, frame_err_d;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (i_clk),
    .rst_n    (i_reset),
    .rx       (i_rx),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  assign sel_data      = i_iorq && (i_addr == DATA_ADDR);
  assign sel_status    = i_iorq && (i_addr == STATUS_ADDR);
  assign strobe        = i_iorq && !iorq_q;
  assign data_wr_stb   = strobe && sel_data && i_wr;
  assign data_rd_stb   = strobe && sel_data && !i_wr;
  assign status_rd_stb = strobe && sel_status && !i_wr;
  assign o_sel         = sel_data || sel_status;
  assign o_tx          = tx_q;

  always_comb begin
    status_byte               = '0;
    status_byte[ST_RX_READY]  = rx_ready_q;
    status_byte[ST_TX_FULL]   = hold_full_q;
    status_byte[ST_OVERRUN]   = overrun_q;
    status_byte[ST_FRAME_ERR] = frame_err_q;
    if (sel_data)        o_data = rx_buf_q;
    else if (sel_status) o_data = status_byte;
    else                 o_data = 8'h00;
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_baud_d   = tx_baud_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_d        = tx_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_take     = 1'b0;
    case (tx_state_q)
      TX_IDLE: tx_take = hold_full_q;
      TX_START: begin
        if (tx_baud_q == BIT_LAST) begin
          tx_baud_d  = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
          tx_d       = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
        end else begin
          tx_baud_d = tx_baud_q + 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_baud_q == BIT_LAST) begin
          tx_baud_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end else begin
          tx_baud_d = tx_baud_q + 16'd1;
        end
      end
      TX_STOP: begin
        // A waiting byte starts right after one stop bit, no idle gap.
        if (tx_baud_q == BIT_LAST) begin
          tx_baud_d  = '0;
          tx_state_d = TX_IDLE;
          tx_take    = hold_full_q;
        end else begin
          tx_baud_d = tx_baud_q + 16'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    if (tx_take) begin
      tx_shift_d  = hold_q;
      hold_full_d = 1'b0;
      tx_state_d  = TX_START;
      tx_baud_d   = '0;
      tx_d        = 1'b0;
    end
    if (data_wr_stb && (!hold_full_q || tx_take)) begin
      hold_d      = i_data;
      hold_full_d = 1'b1;
    end
  end

  always_comb begin
    rx_buf_d    = rx_buf_q;
    rx_ready_d  = rx_ready_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (data_rd_stb) rx_ready_d = 1'b0;
    if (status_rd_stb) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end
    // A fresh byte beats a simultaneous data read; that read saw the old byte.
    if (rx_valid) begin
      rx_buf_d   = rx_byte;
      rx_ready_d = 1'b1;
      if (rx_ready_q && !data_rd_stb) overrun_d = 1'b1;
    end
    if (rx_ferr) frame_err_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      iorq_q      <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_baud_q   <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_q        <= 1'b1;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_buf_q    <= '0;
      rx_ready_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      iorq_q      <= i_iorq;
      tx_state_q  <= tx_state_d;
      tx_baud_q   <= tx_baud_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_q        <= tx_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_buf_q    <= rx_buf_d;
      rx_ready_q  <= rx_ready_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_z80_io_uart.sv
// Self-checking bench for z80_io_uart: a cycle-level reference of the port
// behaviour and serial line, plus hand-computed register and frame values.
`timescale 1ns/1ps
module tb_z80_io_uart;

  localparam int CPB = 8;
  localparam logic [0:9] A5_WAVE = 10'b0101001011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic tx;

  z80_io_uart_if bus ();

  z80_io_uart #(.BASE_ADDR(8'h00), .CLKS_PER_BIT(CPB)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .i_addr  (bus.addr),
    .i_data  (bus.wdata),
    .i_wr    (bus.wr),
    .i_iorq  (bus.iorq),
    .o_data  (bus.rdata),
    .o_sel   (bus.sel),
    .i_rx    (rx),
    .o_tx    (tx)
  );

  always #5 clk = ~clk;

  int vecCount = 0;
  int errCount = 0;

  logic       mdlOn = 1'b0;
  logic       mdlIorqPrev = 1'b0;
  logic       mdlHoldFull = 1'b0;
  logic [7:0] mdlHoldByte = 8'h00;
  logic       mdlLine[$];
  logic [7:0] mdlRxBuf = 8'h00;
  logic       mdlRxReady = 1'b0;
  logic       mdlOverrun = 1'b0;
  logic       mdlFrameErr = 1'b0;
  logic       rxBusy = 1'b0;
  logic [7:0] txBytes[$];

  logic       expTx, isData, isStat, strobe, lvl;
  logic [7:0] expData, monByte;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    vecCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic iorq, input logic wr, input logic [7:0] addr, input logic [7:0] data);
    @(posedge clk);
    #1;
    bus.iorq  = iorq;
    bus.wr    = wr;
    bus.addr  = addr;
    bus.wdata = data;
  endtask

  task automatic cpuWrite(input logic [7:0] addr, input logic [7:0] data, input int cycles);
    applyStimulus(1'b1, 1'b1, addr, data);
    repeat (cycles - 1) @(posedge clk);
    applyStimulus(1'b0, 1'b0, addr, 8'h00);
  endtask

  task automatic cpuRead(input logic [7:0] addr, input logic [7:0] expected, input string name);
    applyStimulus(1'b1, 1'b0, addr, 8'h00);
    @(negedge clk);
    checkOutput(name, bus.rdata, expected);
    applyStimulus(1'b0, 1'b0, addr, 8'h00);
  endtask

  task automatic serialSend(input logic [7:0] b, input logic stopBit);
    rxBusy = 1'b1;
    @(posedge clk);
    #1;
    for (int j = 0; j < 10; j++) begin
      rx = (j == 0) ? 1'b0 : (j == 9) ? stopBit : b[j-1];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    if (stopBit) begin
      if (mdlRxReady) mdlOverrun = 1'b1;
      mdlRxReady = 1'b1;
      mdlRxBuf   = b;
    end else begin
      mdlFrameErr = 1'b1;
    end
    rxBusy = 1'b0;
  endtask

  // Reference: every cycle the line level, select and read data follow the
  // port rules; a frame is 10*CPB levels queued when the hold is taken.
  always @(negedge clk) begin
    if (mdlOn) begin
      expTx  = (mdlLine.size() == 0) ? 1'b1 : mdlLine[0];
      isData = bus.iorq && (bus.addr == 8'h00);
      isStat = bus.iorq && (bus.addr == 8'h01);
      checkOutput("tx_line", {7'b0, tx}, {7'b0, expTx});
      checkOutput("sel", {7'b0, bus.sel}, {7'b0, isData || isStat});
      if (!rxBusy) begin
        expData = isData ? mdlRxBuf :
                  isStat ? {4'b0, mdlFrameErr, mdlOverrun, mdlHoldFull, mdlRxReady} : 8'h00;
        checkOutput("rdata", bus.rdata, expData);
      end
      strobe      = bus.iorq && !mdlIorqPrev;
      mdlIorqPrev = bus.iorq;
      if (mdlLine.size() > 0) void'(mdlLine.pop_front());
      if (mdlLine.size() == 0 && mdlHoldFull) begin
        for (int j = 0; j < 10; j++) begin
          lvl = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : mdlHoldByte[j-1];
          repeat (CPB) mdlLine.push_back(lvl);
        end
        mdlHoldFull = 1'b0;
      end
      if (strobe && isData && bus.wr && !mdlHoldFull) begin
        mdlHoldFull = 1'b1;
        mdlHoldByte = bus.wdata;
      end
      if (strobe && isData && !bus.wr) mdlRxReady = 1'b0;
      if (strobe && isStat && !bus.wr) begin
        mdlOverrun  = 1'b0;
        mdlFrameErr = 1'b0;
      end
    end
  end

  // Serial decoder on o_tx, sampling mid-bit, to collect transmitted bytes.
  initial begin
    forever begin
      @(negedge clk);
      if (mdlOn && tx == 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          monByte[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        txBytes.push_back(monByte);
      end
    end
  end

  initial begin
    bus.iorq  = 1'b0;
    bus.wr    = 1'b0;
    bus.addr  = 8'h00;
    bus.wdata = 8'h00;

    repeat (3) @(negedge clk);
    checkOutput("reset_tx", {7'b0, tx}, 8'h01);
    checkOutput("reset_rdata_unsel", bus.rdata, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h01, 8'h00);
    @(negedge clk);
    checkOutput("reset_sel", {7'b0, bus.sel}, 8'h01);
    checkOutput("reset_status", bus.rdata, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    rst_n = 1'b1;
    mdlOn = 1'b1;

    cpuRead(8'h01, 8'h00, "status_after_reset");
    foreach (txBytes[i]) txBytes.delete(i);
    for (int k = 0; k < 5; k++) begin
      logic [7:0] a;
      a = (k == 0) ? 8'h00 : (k == 1) ? 8'h01 : (k == 2) ? 8'h02 : (k == 3) ? 8'hFF : 8'h80;
      applyStimulus(1'b1, 1'b0, a, 8'h00);
      @(negedge clk);
      checkOutput("sel_sweep", {7'b0, bus.sel}, (k < 2) ? 8'h01 : 8'h00);
      applyStimulus(1'b0, 1'b0, a, 8'h00);
      @(negedge clk);
      checkOutput("sel_no_iorq", {7'b0, bus.sel}, 8'h00);
    end

    cpuWrite(8'h00, 8'hA5, 1);
    repeat (2 + CPB / 2) @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      if (j > 0) repeat (CPB) @(negedge clk);
      checkOutput("a5_bit", {7'b0, tx}, {7'b0, A5_WAVE[j]});
    end
    repeat (2 * CPB) @(posedge clk);
    checkOutput("a5_frames", 8'(txBytes.size()), 8'd1);
    if (txBytes.size() > 0) checkOutput("a5_byte", txBytes[0], 8'hA5);
    txBytes.delete();

    cpuWrite(8'h00, 8'h55, 1);
    cpuWrite(8'h00, 8'h0F, 1);
    cpuRead(8'h01, 8'h02, "status_hold_full");
    cpuWrite(8'h00, 8'h77, 1);
    repeat (25 * CPB) @(posedge clk);
    checkOutput("b2b_frames", 8'(txBytes.size()), 8'd2);
    if (txBytes.size() == 2) begin
      checkOutput("b2b_first", txBytes[0], 8'h55);
      checkOutput("b2b_second", txBytes[1], 8'h0F);
    end
    cpuRead(8'h01, 8'h00, "status_tx_drained");
    txBytes.delete();

    cpuWrite(8'h00, 8'h41, 3);
    repeat (15 * CPB) @(posedge clk);
    checkOutput("held_iorq_frames", 8'(txBytes.size()), 8'd1);
    if (txBytes.size() > 0) checkOutput("held_iorq_byte", txBytes[0], 8'h41);

    serialSend(8'h3C, 1'b1);
    cpuRead(8'h01, 8'h01, "rx_status_ready");
    cpuRead(8'h00, 8'h3C, "rx_data_3c");
    cpuRead(8'h01, 8'h00, "rx_status_cleared");

    serialSend(8'h11, 1'b1);
    serialSend(8'h22, 1'b1);
    cpuRead(8'h01, 8'h05, "rx_status_overrun");
    cpuRead(8'h00, 8'h22, "rx_data_22");
    cpuRead(8'h01, 8'h00, "rx_status_after_overrun");

    serialSend(8'h99, 1'b0);
    cpuRead(8'h01, 8'h08, "rx_status_frame_err");

    rxBusy = 1'b1;
    @(posedge clk);
    #1;
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    rxBusy = 1'b0;
    cpuRead(8'h01, 8'h00, "rx_status_after_glitch");
    cpuRead(8'h00, 8'h22, "rx_data_unchanged");

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
